// File: rtl/lcm_pkg.sv
// Shared definitions for the LCM stage that follows the GCD unit.
// Holds the default width, FSM state encoding and counter sizing.
package lcm_pkg;
    localparam int DEF_WIDTH = 5;
    localparam int CNT_W     = $clog2(2 * DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;
endpackage

// File: rtl/lcm_calc_if.sv
// Valid/ready bundle between the GCD stage, the LCM stage and its sink.
// master drives operands and out_ready; slave is the LCM block.
interface lcm_calc_if #(
    parameter int WIDTH = lcm_pkg::DEF_WIDTH
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   g;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] lcm;
    logic               inexact;

    modport master (
        output in_valid, a, b, g, out_ready,
        input  in_ready, out_valid, lcm, inexact
    );

    modport slave (
        input  in_valid, a, b, g, out_ready,
        output in_ready, out_valid, lcm, inexact
    );
endinterface

// File: rtl/lcm_calc_seq_divider.sv
// Restoring 2*WIDTH / WIDTH divider, one quotient bit per clock.
// The first step runs on the start edge so done follows 2*WIDTH edges.
module seq_divider #(
    parameter int WIDTH = lcm_pkg::DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               done,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH:0]     remainder
);
    localparam int CW = $clog2(2 * WIDTH);

    logic               busy;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] dvd;
    logic [2*WIDTH-1:0] src_dvd;
    logic [2*WIDTH-1:0] src_quo;
    logic [WIDTH:0]     src_rem;
    logic [WIDTH+1:0]   shifted;
    logic               ge;
    logic [WIDTH:0]     rem_nx;
    logic [2*WIDTH-1:0] quo_nx;
    logic [2*WIDTH-1:0] dvd_nx;

    // One restoring step, from fresh operands on start or from state.
    always_comb begin
        src_rem = start ? '0 : remainder;
        src_dvd = start ? dividend : dvd;
        src_quo = start ? '0 : quotient;
        shifted = {src_rem, src_dvd[2*WIDTH-1]};
        ge      = shifted >= {2'b00, divisor};
        rem_nx  = (WIDTH+1)'(ge ? shifted - {2'b00, divisor} : shifted);
        quo_nx  = (2*WIDTH)'({src_quo, ge});
        dvd_nx  = (2*WIDTH)'({src_dvd, 1'b0});
    end

    // Iteration state; done pulses after the last quotient bit lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            dvd       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy      <= 1'b1;
                cnt       <= CW'(2 * WIDTH - 2);
                dvd       <= dvd_nx;
                quotient  <= quo_nx;
                remainder <= rem_nx;
            end else if (busy) begin
                dvd       <= dvd_nx;
                quotient  <= quo_nx;
                remainder <= rem_nx;
                if (cnt == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/lcm_calc.sv
// LCM stage: shift-add multiply a*b, then restoring divide by g.
// Zero operands or a zero g bypass the arithmetic and return 0.
module lcm_calc
    import lcm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    lcm_calc_if.slave  bus
);
    localparam int CW = $clog2(2 * WIDTH);

    state_t             state;
    state_t             state_nx;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod_nx;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   g_r;
    logic [2*WIDTH-1:0] lcm_r;
    logic               inexact_r;
    logic               accept;
    logic               zero_op;
    logic               div_start;
    logic               div_done;
    logic [2*WIDTH-1:0] div_q;
    logic [WIDTH:0]     div_r;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.lcm       = lcm_r;
    assign bus.inexact   = inexact_r;

    assign accept    = bus.in_valid && (state == IDLE);
    assign zero_op   = (bus.a == '0) || (bus.b == '0) || (bus.g == '0);
    assign prod_nx   = product + (mplier[0] ? mcand : '0);
    assign div_start = (state == MUL) && (cnt == '0);

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (prod_nx),
        .divisor   (g_r),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = zero_op ? DONE : MUL;
            MUL:  if (cnt == '0) state_nx = DIV;
            DIV:  if (div_done) state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, multiplier steps and result latching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            product   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            g_r       <= '0;
            lcm_r     <= '0;
            inexact_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        mcand   <= {{WIDTH{1'b0}}, bus.a};
                        mplier  <= bus.b;
                        g_r     <= bus.g;
                        product <= '0;
                        cnt     <= CW'(WIDTH - 1);
                        if (zero_op) begin
                            lcm_r     <= '0;
                            inexact_r <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    product <= prod_nx;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else           cnt <= CW'(2 * WIDTH - 1);
                end
                DIV: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    if (div_done) begin
                        lcm_r     <= div_q;
                        inexact_r <= (div_r != '0);
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end
endmodule
